cpu_control: RTL and testbench

Instruction register, decoder and control FSM for the 16-bit Simple RISC Machine datapath. Sits directly upstream of regfile and sequences its readnum/writenum/write, plus the A/B/C/status load strobes and operand muxes. Accepts one instruction at a time over a load/start handshake. Raises w when idle.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_control_instr_decoder.sv | 49 ++++
 rtl/cpu_control.sv | 134 +++++++++++++
 tb/tb_cpu_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC Machine control block:
// opcodes, ALU ops, writeback selects, FSM states and instruction classes.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GETA   = 3'd2,
        S_GETB   = 3'd3,
        S_EXEC   = 3'd4,
        S_WREG   = 3'd5,
        S_WIMM   = 3'd6
    } state_t;

    // IC_MOVR covers every single-operand op (MOV reg and MVN): B only, A forced to 0.
    typedef enum logic [2:0] {
        IC_MOVI    = 3'd0,
        IC_MOVR    = 3'd1,
        IC_ALU2    = 3'd2,
        IC_CMP     = 3'd3,
        IC_ILLEGAL = 3'd4
    } iclass_t;

endpackage

// File: rtl/cpu_control_instr_decoder.sv
// Combinational instruction decode: IR -> register fields, immediates and
// instruction class used by the control FSM.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic [DATA_W-1:0] ir,
    output logic [REG_W-1:0]  rn,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rm,
    output logic [1:0]        shift,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output iclass_t           iclass
);

    logic [2:0] opc;

    assign opc    = ir[15:13];
    assign alu_op = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

    always_comb begin
        iclass = IC_ILLEGAL;
        case (opc)
            OPC_MOV: begin
                if (alu_op == OP_MOVI)      iclass = IC_MOVI;
                else if (alu_op == OP_MOVR) iclass = IC_MOVR;
            end
            OPC_ALU: begin
                case (alu_op)
                    OP_CMP:  iclass = IC_CMP;
                    OP_MVN:  iclass = IC_MOVR;
                    default: iclass = IC_ALU2;
                endcase
            end
            default: iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Instruction register plus Moore control FSM sequencing the regfile and
// A/B/C/status datapath strobes for one instruction per load/start handshake.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic              s,
    output logic              w,
    output logic [REG_W-1:0]  readnum,
    output logic [REG_W-1:0]  writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              illegal_q, illegal_d;

    logic [REG_W-1:0]  rn, rd, rm;
    iclass_t           iclass;

    instr_decoder #(.DATA_W(DATA_W), .REG_W(REG_W)) u_dec (
        .ir     (ir_q),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .shift  (shift),
        .alu_op (ALUop),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .iclass (iclass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        w         = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = VSEL_C;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (load) ir_d = in;
                if (s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    IC_MOVI:         state_d = S_WIMM;
                    IC_MOVR:         state_d = S_GETB;
                    IC_ALU2, IC_CMP: state_d = S_GETA;
                    default: begin
                        state_d   = S_WAIT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GETB;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                asel = (iclass == IC_MOVR);
                // CMP only updates status flags and never writes back.
                if (iclass == IC_CMP) begin
                    loads   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WREG;
                end
            end
            S_WREG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_WIMM: begin
                writenum = rn;
                vsel     = VSEL_IMM8;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboarded bench for cpu_control: stimulus pushes per-instruction
// expectations, a negedge monitor summarises each execution and compares.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset, load, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    cpu_control dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat, nwr, wnum, vsel, na, ra, nb, rb, nc, ns, asel, ill, sx8, sh, alu, sx5;
    } rec_t;

    rec_t        expq[$];
    int          errs   = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    bit          model_ill = 1'b0;
    logic [15:0] model_ir = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per-instruction summary derived from the ISA rules, not the FSM.
    function automatic rec_t model(input logic [15:0] ir);
        rec_t r   = '{default: 0};
        int   opc = int'(ir[15:13]);
        int   op  = int'(ir[12:11]);
        int   rn  = int'(ir[10:8]);
        int   rd  = int'(ir[7:5]);
        int   rm  = int'(ir[2:0]);
        logic [15:0] x8 = {{8{ir[7]}}, ir[7:0]};
        logic [15:0] x5 = {{11{ir[4]}}, ir[4:0]};
        if (opc == 6 && op == 2) begin
            r.lat = 3; r.nwr = 1; r.wnum = rn; r.vsel = 2; r.sx8 = int'(x8);
        end else if (opc == 6 && op == 0 || opc == 5 && op == 3) begin
            r.lat = 5; r.nb = 1; r.rb = rm; r.nc = 1; r.asel = 1;
            r.nwr = 1; r.wnum = rd; r.sx8 = int'(x8);
        end else if (opc == 5 && op != 1) begin
            r.lat = 6; r.na = 1; r.ra = rn; r.nb = 1; r.rb = rm; r.nc = 1;
            r.nwr = 1; r.wnum = rd; r.sx8 = int'(x8);
        end else if (opc == 5) begin
            r.lat = 5; r.na = 1; r.ra = rn; r.nb = 1; r.rb = rm; r.ns = 1;
        end else begin
            r.lat = 2;
        end
        if (r.nc + r.ns > 0) begin
            r.sh = int'(ir[4:3]); r.alu = op; r.sx5 = int'(x5);
        end
        return r;
    endfunction

    task automatic push_exp();
        rec_t r = model(model_ir);
        if (r.lat == 2) model_ill = 1'b1;
        r.ill = int'(model_ill);
        expq.push_back(r);
    endtask

    task automatic cmp_rec(input rec_t e, input rec_t o);
        chk("latency",  o.lat,  e.lat);  chk("n_write", o.nwr,  e.nwr);
        chk("writenum", o.wnum, e.wnum); chk("vsel",    o.vsel, e.vsel);
        chk("n_loada",  o.na,   e.na);   chk("read_a",  o.ra,   e.ra);
        chk("n_loadb",  o.nb,   e.nb);   chk("read_b",  o.rb,   e.rb);
        chk("n_loadc",  o.nc,   e.nc);   chk("n_loads", o.ns,   e.ns);
        chk("asel",     o.asel, e.asel); chk("illegal", o.ill,  e.ill);
        chk("sximm8",   o.sx8,  e.sx8);  chk("shift",   o.sh,   e.sh);
        chk("aluop",    o.alu,  e.alu);  chk("sximm5",  o.sx5,  e.sx5);
    endtask

    // Monitor: summarise each busy stretch (w low) and score it when w returns.
    initial begin
        rec_t o = '{default: 0};
        bit   busy = 1'b0;
        logic prev_w = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("one_strobe", 32'($countones({loada, loadb, loadc | loads, write}) <= 1), 1);
                chk("idle_selects", {(loada | loadb) ? 3'd0 : readnum,
                                     write ? 3'd0 : writenum, bsel,
                                     write ? 2'd0 : vsel}, 0);
                if (!w) begin
                    if (prev_w) begin
                        o    = '{default: 0};
                        busy = 1'b1;
                    end
                    o.lat++;
                    if (write) begin
                        o.nwr++; o.wnum = int'(writenum); o.vsel = int'(vsel); o.sx8 = int'(sximm8);
                    end
                    if (loada) begin o.na++; o.ra = int'(readnum); end
                    if (loadb) begin o.nb++; o.rb = int'(readnum); end
                    if (loadc | loads) begin
                        o.nc += int'(loadc); o.ns += int'(loads); o.asel = int'(asel);
                        o.sh = int'(shift); o.alu = int'(ALUop); o.sx5 = int'(sximm5);
                    end
                end else if (busy) begin
                    busy = 1'b0;
                    o.lat++;
                    o.ill = int'(illegal);
                    if (expq.size() == 0) chk("unexpected_completion", 1, 0);
                    else cmp_rec(expq.pop_front(), o);
                end
                prev_w = w;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!w && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", w, 1);
    endtask

    task automatic issue(input logic [15:0] instr, input bit together);
        wait_idle();
        in   = instr;
        load = 1'b1;
        s    = together;
        @(posedge clk); #1;
        load     = 1'b0;
        model_ir = instr;
        if (!together) begin
            s = 1'b1;
            @(posedge clk); #1;
        end
        s = 1'b0;
        push_exp();
    endtask

    function automatic logic [15:0] rand_instr();
        logic [10:0] lo = 11'($urandom);
        case ($urandom_range(0, 4))
            0:       return {3'b110, 2'b10, lo};
            1:       return {3'b110, 2'b00, lo};
            2, 3:    return {3'b101, 2'($urandom), lo};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1; load = 1'b0; s = 1'b0; in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_w", w, 1);
        chk("rst_strobes", {write, loada, loadb, loadc, loads, asel, bsel}, 0);
        chk("rst_sel", {readnum, writenum, vsel}, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ir", {sximm8, shift, ALUop}, 0);
        mon_en = 1'b1;

        issue(16'hD007, 1'b0);
        issue(16'hD480, 1'b1);
        issue(16'hA148, 1'b0);
        issue(16'hA900, 1'b1);
        issue(16'hC065, 1'b0);
        // load mid-execution must be ignored; R3 is still the destination
        issue(16'hC065, 1'b1);
        @(posedge clk); #1;
        in = 16'hFFFF; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        issue(16'hE000, 1'b0);

        // s held high: IR re-executes right after returning to wait
        wait_idle();
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; model_ir = 16'hA148;
        push_exp();
        n = 0;
        while (!w && n < 50) begin @(posedge clk); #1; n++; end
        chk("held_s_timeout", w, 1);
        push_exp();
        @(posedge clk); #1;
        s = 1'b0;

        for (int i = 0; i < 40; i++) issue(rand_instr(), 1'($urandom));

        // reset during S_GETB of an ADD
        wait_idle();
        @(posedge clk); #1;
        chk("queue_drained", expq.size(), 0);
        mon_en = 1'b0;
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("in_getb", {loadb, readnum}, {1'b1, 3'd0});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; model_ill = 1'b0;
        chk("mid_rst_w", w, 1);
        chk("mid_rst_strobes", {write, loada, loadb, loadc, loads}, 0);
        chk("mid_rst_ir", {sximm8, sximm5, shift, ALUop}, 0);
        chk("mid_rst_illegal", illegal, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_write", {write, w}, 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
